// File: rtl/mult_sequencer.sv
// Sequential unsigned shift-add multiplier: one iteration per clock, WIDTH iterations per product.
// Accepts a start only in IDLE; the product halves hold until the next completion.
module mult_sequencer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             multstart,
    input  logic [WIDTH-1:0] mc_in,
    input  logic [WIDTH-1:0] mp_in,
    output logic             multbusy,
    output logic             done,
    output logic [WIDTH-1:0] prod_lo,
    output logic [WIDTH-1:0] prod_hi
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] mc_q;
    logic [WIDTH-1:0] mp_q;
    logic [WIDTH-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH:0]   sum_d;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] mp_d;

    // The add's carry lands in the accumulator MSB after the right shift.
    always_comb begin
        sum_d = {1'b0, acc_q} + (mp_q[0] ? {1'b0, mc_q} : {(WIDTH+1){1'b0}});
        acc_d = sum_d[WIDTH:1];
        mp_d  = {sum_d[0], mp_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            mc_q     <= '0;
            mp_q     <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            multbusy <= 1'b0;
            done     <= 1'b0;
            prod_lo  <= '0;
            prod_hi  <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (multstart) begin
                        mc_q     <= mc_in;
                        mp_q     <= mp_in;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        multbusy <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    mp_q  <= mp_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        prod_hi  <= acc_d;
                        prod_lo  <= mp_d;
                        done     <= 1'b1;
                        multbusy <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_sequencer.sv
// Scoreboard bench for mult_sequencer: expected products are queued at start, checked on done.
module tb_mult_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        multstart = 1'b0;
    logic [15:0] mc_in = '0;
    logic [15:0] mp_in = '0;
    logic        multbusy;
    logic        done;
    logic [15:0] prod_lo;
    logic [15:0] prod_hi;

    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    logic        done_prev = 1'b0;
    logic [31:0] exp_q[$];

    mult_sequencer #(.WIDTH(16), .CNT_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .multstart (multstart),
        .mc_in     (mc_in),
        .mp_in     (mp_in),
        .multbusy  (multbusy),
        .done      (done),
        .prod_lo   (prod_lo),
        .prod_hi   (prod_hi)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Output side of the scoreboard: every done pulse pops one expected product.
    always @(negedge clk) begin
        if (done_prev) check("done_one_cycle", {31'd0, done}, 32'd0);
        if (!reset && done) begin
            done_cnt++;
            if (exp_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
            else check("product", {prod_hi, prod_lo}, exp_q.pop_front());
        end
        done_prev = done && !reset;
    end

    // Called at a negedge; returns at the negedge where done is seen (or after an abort).
    task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                         input int glitch_at, input int rst_at, input bit scramble);
        int          n;
        int          busy;
        int          dc;
        bit          held;
        logic [31:0] p0;
        multstart = 1'b1;
        mc_in     = a;
        mp_in     = b;
        exp_q.push_back(32'(a) * 32'(b));
        @(negedge clk);
        multstart = 1'b0;
        n    = 1;
        busy = 0;
        held = 1'b1;
        p0   = {prod_hi, prod_lo};
        while (!done && n < 40) begin
            if (multbusy) busy++;
            if ({prod_hi, prod_lo} !== p0) held = 1'b0;
            if (n == rst_at) begin
                reset = 1'b1;
                #1;
                check("abort_busy", {31'd0, multbusy}, 32'd0);
                check("abort_done", {31'd0, done}, 32'd0);
                check("abort_prod", {prod_hi, prod_lo}, 32'd0);
                void'(exp_q.pop_back());
                dc = done_cnt;
                @(negedge clk);
                reset = 1'b0;
                repeat (20) @(negedge clk);
                check("abort_no_done", done_cnt, dc);
                check("abort_idle_busy", {31'd0, multbusy}, 32'd0);
                return;
            end
            if (glitch_at != 0 && n == glitch_at) begin
                multstart = 1'b1;
                mc_in     = 16'd7;
                mp_in     = 16'd7;
            end else begin
                multstart = 1'b0;
            end
            if (scramble) begin
                mc_in = 16'($urandom);
                mp_in = 16'($urandom);
            end
            @(negedge clk);
            n++;
        end
        multstart = 1'b0;
        check("latency", n, 17);
        check("busy_cycles", busy, 16);
        check("busy_at_done", {31'd0, multbusy}, 32'd0);
        check("prod_hold", {31'd0, held}, 32'd1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_busy", {31'd0, multbusy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_prod", {prod_hi, prod_lo}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        do_op(16'd3, 16'd5, 0, 0, 1'b0);
        repeat (3) @(negedge clk);
        do_op(16'hFFFF, 16'hFFFF, 0, 0, 1'b0);
        repeat (2) @(negedge clk);
        do_op(16'h1234, 16'h0010, 5, 0, 1'b0);
        repeat (2) @(negedge clk);
        do_op(16'd2, 16'd2, 0, 0, 1'b0);
        do_op(16'h0000, 16'hABCD, 0, 0, 1'b0);
        repeat (2) @(negedge clk);
        do_op(16'h0100, 16'h0100, 0, 0, 1'b1);
        repeat (2) @(negedge clk);
        do_op(16'hA5A5, 16'h5A5A, 0, 0, 1'b0);
        repeat (2) @(negedge clk);
        do_op(16'h00FF, 16'h0101, 0, 8, 1'b0);
        do_op(16'h0001, 16'h8000, 0, 0, 1'b0);
        repeat (3) @(negedge clk);

        check("scoreboard_empty", exp_q.size(), 0);
        check("done_total", done_cnt, 8);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
